// File: rtl/bsg_manycore_accel_store_sequencer_pkg.sv
// Shared types and constants for the accelerator burst store sequencer.
package bsg_manycore_accel_store_sequencer_pkg;

    localparam int DefaultMaxOutCredits = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FENCE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/bsg_manycore_accel_store_sequencer.sv
// Burst store sequencer: streams a counted run of data words as remote stores to consecutive addresses.
// Define BSG_MANYCORE_ACCEL_STORE_SEQ_FENCE_EN to hold done_o until every store has been acknowledged.
module bsg_manycore_accel_store_sequencer
    import bsg_manycore_accel_store_sequencer_pkg::*;
#(
    parameter int addr_width_p           = 32,
    parameter int data_width_p           = 32,
    parameter int x_cord_width_p         = 4,
    parameter int y_cord_width_p         = 4,
    parameter int len_width_p            = 16,
    parameter int max_out_credits_p      = DefaultMaxOutCredits,
    parameter int credit_counter_width_p = $clog2(max_out_credits_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic                              start_v_i,
    output logic                              start_ready_o,
    input  logic [addr_width_p-1:0]           start_addr_i,
    input  logic [x_cord_width_p-1:0]         start_x_i,
    input  logic [y_cord_width_p-1:0]         start_y_i,
    input  logic [len_width_p-1:0]            start_len_i,

    input  logic                              data_v_i,
    input  logic [data_width_p-1:0]           data_i,
    output logic                              data_yumi_o,

    output logic                              out_v_o,
    input  logic                              out_ready_i,
    output logic [addr_width_p-1:0]           out_addr_o,
    output logic [data_width_p-1:0]           out_data_o,
    output logic [x_cord_width_p-1:0]         out_x_o,
    output logic [y_cord_width_p-1:0]         out_y_o,
    input  logic [credit_counter_width_p-1:0] out_credits_used_i,

    output logic                              busy_o,
    output logic                              done_o
);

    localparam logic [credit_counter_width_p-1:0] CreditLimit =
        credit_counter_width_p'(max_out_credits_p);

    seq_state_e                  state_q, state_d;
    logic [addr_width_p-1:0]     addr_q, addr_d;
    logic [len_width_p-1:0]      count_q, count_d;
    logic [x_cord_width_p-1:0]   x_q, x_d;
    logic [y_cord_width_p-1:0]   y_q, y_d;
    logic                        done_q, done_d;

    logic creditOk;
    logic sendFire;

    // Issue is gated combinationally so a full credit counter stalls in the same cycle.
    assign creditOk      = (out_credits_used_i < CreditLimit);
    assign out_v_o       = (state_q == SEND) & data_v_i & creditOk;
    assign sendFire      = out_v_o & out_ready_i;
    assign data_yumi_o   = sendFire;
    assign out_data_o    = data_i;
    assign out_addr_o    = addr_q;
    assign out_x_o       = x_q;
    assign out_y_o       = y_q;
    assign start_ready_o = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_v_i) begin
                    addr_d  = start_addr_i;
                    x_d     = start_x_i;
                    y_d     = start_y_i;
                    count_d = start_len_i;
                    if (start_len_i != '0) begin
                        state_d = SEND;
                    end else begin
`ifdef BSG_MANYCORE_ACCEL_STORE_SEQ_FENCE_EN
                        state_d = FENCE;
`else
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            SEND: begin
                if (sendFire) begin
                    addr_d  = addr_q + addr_width_p'(1);
                    count_d = count_q - len_width_p'(1);
                    if (count_q == len_width_p'(1)) begin
`ifdef BSG_MANYCORE_ACCEL_STORE_SEQ_FENCE_EN
                        state_d = FENCE;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef BSG_MANYCORE_ACCEL_STORE_SEQ_FENCE_EN
            FENCE: begin
                if (out_credits_used_i == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_bsg_manycore_accel_store_sequencer.sv
// Self-checking bench for the burst store sequencer: directed scenarios then randomized traffic
// compared cycle by cycle against a transaction-level model of the burst.
module tb_bsg_manycore_accel_store_sequencer;

    localparam int AddrWidth   = 8;
    localparam int DataWidth   = 32;
    localparam int XWidth      = 4;
    localparam int YWidth      = 4;
    localparam int LenWidth    = 16;
    localparam int CreditWidth = 6;
    localparam int MaxCredits  = 32;
`ifdef BSG_MANYCORE_ACCEL_STORE_SEQ_FENCE_EN
    localparam bit FenceEn = 1'b1;
`else
    localparam bit FenceEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   resetN = 1'b0;
    logic                   startV = 1'b0;
    logic                   startReady;
    logic [AddrWidth-1:0]   startAddr = '0;
    logic [XWidth-1:0]      startX = '0;
    logic [YWidth-1:0]      startY = '0;
    logic [LenWidth-1:0]    startLen = '0;
    logic                   dataV = 1'b0;
    logic [DataWidth-1:0]   dataWord = '0;
    logic                   dataYumi;
    logic                   outV;
    logic                   outReady = 1'b0;
    logic [AddrWidth-1:0]   outAddr;
    logic [DataWidth-1:0]   outData;
    logic [XWidth-1:0]      outX;
    logic [YWidth-1:0]      outY;
    logic [CreditWidth-1:0] creditsUsed = '0;
    logic                   busy;
    logic                   done;

    int checkCount = 0;
    int passCount  = 0;

    // Burst-level reference model: whether a command is in flight, how many words remain,
    // the next address, and whether a completion pulse is due this cycle.
    bit mBusy = 0;
    bit mFencing = 0;
    bit mDone = 0;
    int mRemaining = 0;
    int mAddr = 0;
    int mX = 0;
    int mY = 0;
    int srcIdx = 0;

    always #5 clk = ~clk;

    bsg_manycore_accel_store_sequencer #(
        .addr_width_p          (AddrWidth),
        .data_width_p          (DataWidth),
        .x_cord_width_p        (XWidth),
        .y_cord_width_p        (YWidth),
        .len_width_p           (LenWidth),
        .credit_counter_width_p(CreditWidth),
        .max_out_credits_p     (MaxCredits)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (resetN),
        .start_v_i         (startV),
        .start_ready_o     (startReady),
        .start_addr_i      (startAddr),
        .start_x_i         (startX),
        .start_y_i         (startY),
        .start_len_i       (startLen),
        .data_v_i          (dataV),
        .data_i            (dataWord),
        .data_yumi_o       (dataYumi),
        .out_v_o           (outV),
        .out_ready_i       (outReady),
        .out_addr_o        (outAddr),
        .out_data_o        (outData),
        .out_x_o           (outX),
        .out_y_o           (outY),
        .out_credits_used_i(creditsUsed),
        .busy_o            (busy),
        .done_o            (done)
    );

    // Source stream words are distinct so any reordering or drop shows up in the data.
    function automatic logic [DataWidth-1:0] wordFor(input int idx);
        return 32'hA5000000 ^ (32'(idx) * 32'h9E3779B1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model at the falling edge, then advance the model.
    task automatic stepCycle();
        bit sending;
        bit expOutV;
        bit expYumi;
        bit nextDone;
        dataWord = wordFor(srcIdx);
        @(negedge clk);
        sending = mBusy && !mFencing;
        expOutV = sending && dataV && (int'(creditsUsed) < MaxCredits);
        expYumi = expOutV && outReady;
        checkOutput("startReady", 64'(startReady), 64'(!mBusy));
        checkOutput("busy", 64'(busy), 64'(mBusy));
        checkOutput("done", 64'(done), 64'(mDone));
        checkOutput("outV", 64'(outV), 64'(expOutV));
        checkOutput("dataYumi", 64'(dataYumi), 64'(expYumi));
        if (expOutV) begin
            checkOutput("outAddr", 64'(outAddr), 64'(mAddr));
            checkOutput("outData", 64'(outData), 64'(wordFor(srcIdx)));
            checkOutput("outX", 64'(outX), 64'(mX));
            checkOutput("outY", 64'(outY), 64'(mY));
        end

        nextDone = 0;
        if (!mBusy) begin
            if (startV) begin
                mAddr      = int'(startAddr);
                mX         = int'(startX);
                mY         = int'(startY);
                mRemaining = int'(startLen);
                if (mRemaining != 0) begin
                    mBusy    = 1;
                    mFencing = 0;
                end else if (FenceEn) begin
                    mBusy    = 1;
                    mFencing = 1;
                end else begin
                    nextDone = 1;
                end
            end
        end else if (!mFencing) begin
            if (expYumi) begin
                mAddr = (mAddr + 1) % (1 << AddrWidth);
                mRemaining--;
                srcIdx++;
                if (mRemaining == 0) begin
                    if (FenceEn) begin
                        mFencing = 1;
                    end else begin
                        mBusy    = 0;
                        nextDone = 1;
                    end
                end
            end
        end else if (creditsUsed == '0) begin
            mBusy    = 0;
            mFencing = 0;
            nextDone = 1;
        end
        mDone = nextDone;
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic applyStimulus(input int addr, input int x, input int y, input int len);
        startV    = 1'b1;
        startAddr = AddrWidth'(addr);
        startX    = XWidth'(x);
        startY    = YWidth'(y);
        startLen  = LenWidth'(len);
        stepCycle();
        startV    = 1'b0;
    endtask

    // Asynchronous reset taken between clock edges; outputs must settle to reset values at once.
    task automatic applyReset();
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("rstOutV", 64'(outV), 64'(0));
        checkOutput("rstYumi", 64'(dataYumi), 64'(0));
        checkOutput("rstBusy", 64'(busy), 64'(0));
        checkOutput("rstReady", 64'(startReady), 64'(1));
        checkOutput("rstDone", 64'(done), 64'(0));
        checkOutput("rstAddr", 64'(outAddr), 64'(0));
        checkOutput("rstX", 64'(outX), 64'(0));
        checkOutput("rstY", 64'(outY), 64'(0));
        mBusy    = 0;
        mFencing = 0;
        mDone    = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyReset();

        dataV       = 1'b1;
        outReady    = 1'b1;
        creditsUsed = '0;

        $display("[TB] basic burst");
        applyStimulus(8'h10, 2, 3, 4);
        runCycles(6);

        $display("[TB] zero-length start");
        applyStimulus(8'h40, 1, 1, 0);
        runCycles(3);

        $display("[TB] credit stall");
        applyStimulus(8'h20, 5, 6, 6);
        runCycles(2);
        creditsUsed = CreditWidth'(MaxCredits);
        runCycles(5);
        creditsUsed = '0;
        runCycles(6);

        $display("[TB] address wrap");
        applyStimulus(8'hFE, 7, 1, 4);
        runCycles(6);

        $display("[TB] back-pressure with busy start");
        applyStimulus(8'h80, 3, 2, 6);
        for (int i = 0; i < 10; i++) begin
            outReady  = (i % 2) == 1;
            startV    = (i == 3);
            startAddr = 8'h33;
            startLen  = 16'd2;
            stepCycle();
        end
        startV   = 1'b0;
        outReady = 1'b1;
        runCycles(6);

        $display("[TB] reset mid-burst");
        applyStimulus(8'h50, 4, 4, 8);
        runCycles(2);
        applyReset();
        applyStimulus(8'h60, 1, 2, 3);
        runCycles(5);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            int r;
            dataV    = $urandom_range(0, 9) < 8;
            outReady = $urandom_range(0, 9) < 7;
            r = int'($urandom_range(0, 9));
            if (r < 6)      creditsUsed = '0;
            else if (r < 8) creditsUsed = CreditWidth'($urandom_range(1, MaxCredits - 1));
            else            creditsUsed = CreditWidth'($urandom_range(MaxCredits, MaxCredits + 8));
            startV    = $urandom_range(0, 3) == 0;
            startAddr = AddrWidth'($urandom);
            startX    = XWidth'($urandom);
            startY    = YWidth'($urandom);
            startLen  = LenWidth'($urandom_range(0, 9));
            stepCycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
